// File: rtl/uart_pkg.sv
// Shared UART types, constants and baud-divider helper, used by uart_rx now and uart_tx later.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;

    // Rounded clock cycles per oversample tick.
    function automatic int uart_div(input int clock_freq, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clock_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: ready/valid data plus one-cycle error pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_bits;
    logic                      data_valid;
    logic                      data_ready;
    logic                      framing_error;
    logic                      overrun;

    modport master (
        output data_bits,
        output data_valid,
        output framing_error,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_bits,
        input  data_valid,
        input  framing_error,
        input  overrun,
        output data_ready
    );

endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV cycles, phase realigned by restart.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: synchronizer, oversampled majority-vote framing FSM, single-entry holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       io_rxd,
    uart_rx_if.master  io
);

    localparam int            DIV    = uart_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int            SW     = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] VOTE_A = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] VOTE_B = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] VOTE_C = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0]                sync_q;
    logic [1:0]                warm_q;
    logic                      prev_q;
    uart_state_e               state_q;
    logic [SW-1:0]             samp_q;
    logic [SW-1:0]             samp_d;
    logic [2:0]                bit_q;
    logic [1:0]                vote_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      fe_q;
    logic                      ov_q;

    logic rxd_s;
    logic start_edge;
    logic restart;
    logic tick;
    logic vote_now;
    logic maj;

    // The synchronizer resets to idle-high, so its output is only trusted once
    // real line samples have propagated through both flops (warm_q[1]); this keeps
    // a line held low across reset release from looking like a start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            warm_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], io_rxd};
            warm_q <= {warm_q[0], 1'b1};
            if (warm_q[1]) begin
                prev_q <= rxd_s;
            end
        end
    end

    assign rxd_s      = sync_q[1];
    assign start_edge = warm_q[1] && prev_q && !rxd_s;
    assign restart    = (state_q == IDLE) && start_edge;

    uart_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    assign samp_d   = samp_q + 1'b1;
    assign vote_now = tick && (samp_d == VOTE_C);
    assign maj      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            vote_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            fe_q <= 1'b0;
            ov_q <= 1'b0;
            if (valid_q && io.data_ready) begin
                valid_q <= 1'b0;
            end
            // The sample index keeps running across bits: it wraps every
            // OVERSAMPLE ticks, so every bit centre lands on the same indices.
            if (tick) begin
                samp_q <= samp_d;
                if (samp_d == VOTE_A) vote_q[0] <= rxd_s;
                if (samp_d == VOTE_B) vote_q[1] <= rxd_s;
            end
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q <= START;
                        samp_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                START: begin
                    if (vote_now) begin
                        state_q <= maj ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (vote_now) begin
                        shift_q <= {maj, shift_q[UART_DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (vote_now) begin
                        if (maj) begin
                            state_q <= IDLE;
                            if (!valid_q || io.data_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ov_q <= 1'b1;
                            end
                        end else begin
                            state_q <= BREAK;
                            fe_q    <= 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.data_bits     = data_q;
    assign io.data_valid    = valid_q;
    assign io.framing_error = fe_q;
    assign io.overrun       = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serializes frames at 50 MHz / 115200 baud and checks bytes and flags.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CYC  = 434;   // 50e6 / 115200, rounded
    localparam int FAST_CYC = 423;   // 2.5 % faster sender
    // Stop-bit vote edge after the start falling edge: 3 sync/detect edges + 153 ticks * 27 cycles.
    localparam int DECIDE_EDGE = 4134;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic rxd     = 1'b1;

    uart_rx_if u_if ();

    uart_rx #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (115_200),
        .OVERSAMPLE (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io_rxd  (rxd),
        .io      (u_if)
    );

    always #10 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int         rx_n         = 0;
    int         valid_cycles = 0;
    int         fe_cycles    = 0;
    int         ov_cycles    = 0;
    int         unstable     = 0;
    logic [7:0] rx_log [0:63];
    logic       prev_hold    = 1'b0;
    logic [7:0] prev_bits    = 8'h00;

    int n0, v0, f0, o0;

    always @(negedge clock) begin
        if (u_if.data_valid && u_if.data_ready) begin
            rx_log[rx_n[5:0]] <= u_if.data_bits;
            rx_n <= rx_n + 1;
            $display("tb: byte accepted 0x%02h at %0t", u_if.data_bits, $time);
        end
        if (u_if.data_valid)    valid_cycles <= valid_cycles + 1;
        if (u_if.framing_error) fe_cycles    <= fe_cycles + 1;
        if (u_if.overrun)       ov_cycles    <= ov_cycles + 1;
        if (reset_n && prev_hold && (u_if.data_bits !== prev_bits)) unstable <= unstable + 1;
        prev_hold <= reset_n && u_if.data_valid && !u_if.data_ready;
        prev_bits <= u_if.data_bits;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic snap();
        settle();
        n0 = rx_n;
        v0 = valid_cycles;
        f0 = fe_cycles;
        o0 = ov_cycles;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_v, input int stop_len);
        @(posedge clock);
        #2 rxd = 1'b0;
        repeat (bc) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            #2 rxd = b[i];
            repeat (bc) @(posedge clock);
        end
        #2 rxd = stop_v;
        repeat (bc * stop_len) @(posedge clock);
        #2 rxd = 1'b1;
        $display("tb: sent 0x%02h bit_cycles=%0d stop=%0b", b, bc, stop_v);
    endtask

    initial begin
        #1_800_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.data_ready = 1'b1;
        repeat (4) @(posedge clock);
        settle();
        check("reset_bits",  32'(u_if.data_bits),     32'h00);
        check("reset_valid", 32'(u_if.data_valid),    32'h0);
        check("reset_fe",    32'(u_if.framing_error), 32'h0);
        check("reset_ov",    32'(u_if.overrun),       32'h0);
        check("reset_state", 32'(dut.state_q),        32'(IDLE));
        @(posedge clock);
        #2 reset_n = 1'b1;
        idle(BIT_CYC);

        // Single byte with ready held high.
        snap();
        send_byte(8'h55, BIT_CYC, 1'b1, 1);
        idle(BIT_CYC / 2);
        settle();
        check("t1_count",  32'(rx_n - n0),         32'd1);
        check("t1_byte",   32'(rx_log[n0[5:0]]),   32'h55);
        check("t1_vcycles", 32'(valid_cycles - v0), 32'd1);
        check("t1_fe",     32'(fe_cycles - f0),    32'd0);
        check("t1_ov",     32'(ov_cycles - o0),    32'd0);

        // Quarter-bit glitch is a false start.
        snap();
        @(posedge clock);
        #2 rxd = 1'b0;
        repeat (BIT_CYC / 4) @(posedge clock);
        #2 rxd = 1'b1;
        idle(2 * BIT_CYC);
        settle();
        check("t2_vcycles", 32'(valid_cycles - v0), 32'd0);
        check("t2_fe",      32'(fe_cycles - f0),    32'd0);
        check("t2_ov",      32'(ov_cycles - o0),    32'd0);
        check("t2_state",   32'(dut.state_q),       32'(IDLE));
        snap();
        send_byte(8'hA5, BIT_CYC, 1'b1, 1);
        idle(BIT_CYC / 2);
        settle();
        check("t2_count", 32'(rx_n - n0),       32'd1);
        check("t2_byte",  32'(rx_log[n0[5:0]]), 32'hA5);

        // Stop bit held low for two bit periods.
        snap();
        send_byte(8'hA3, BIT_CYC, 1'b0, 2);
        idle(BIT_CYC);
        settle();
        check("t3_fe",      32'(fe_cycles - f0),    32'd1);
        check("t3_vcycles", 32'(valid_cycles - v0), 32'd0);
        check("t3_state",   32'(dut.state_q),       32'(IDLE));
        snap();
        send_byte(8'h3C, BIT_CYC, 1'b1, 1);
        idle(BIT_CYC / 2);
        settle();
        check("t3_count", 32'(rx_n - n0),       32'd1);
        check("t3_byte",  32'(rx_log[n0[5:0]]), 32'h3C);
        check("t3_fe2",   32'(fe_cycles - f0),  32'd0);

        // Backpressure: second byte overruns the held first byte.
        @(posedge clock);
        #2 u_if.data_ready = 1'b0;
        snap();
        send_byte(8'h12, BIT_CYC, 1'b1, 1);
        idle(BIT_CYC);
        send_byte(8'h34, BIT_CYC, 1'b1, 1);
        idle(BIT_CYC);
        settle();
        check("t4_valid", 32'(u_if.data_valid), 32'h1);
        check("t4_bits",  32'(u_if.data_bits),  32'h12);
        check("t4_ov",    32'(ov_cycles - o0),  32'd1);
        check("t4_count", 32'(rx_n - n0),       32'd0);
        @(posedge clock);
        #2 u_if.data_ready = 1'b1;
        @(posedge clock);
        #2 u_if.data_ready = 1'b0;
        settle();
        check("t4_drain_count", 32'(rx_n - n0),       32'd1);
        check("t4_drain_byte",  32'(rx_log[n0[5:0]]), 32'h12);
        check("t4_drain_valid", 32'(u_if.data_valid), 32'h0);
        idle(BIT_CYC);
        settle();
        check("t4_after_count", 32'(rx_n - n0),       32'd1);
        check("t4_after_valid", 32'(u_if.data_valid), 32'h0);
        check("t4_stable",      32'(unstable),        32'd0);

        // Ready rises exactly in the cycle 0x34 is delivered.
        send_byte(8'h12, BIT_CYC, 1'b1, 1);
        idle(BIT_CYC);
        snap();
        check("t5_held", 32'(u_if.data_bits), 32'h12);
        fork
            send_byte(8'h34, BIT_CYC, 1'b1, 1);
            begin
                @(posedge clock);
                repeat (DECIDE_EDGE - 1) @(posedge clock);
                #2 u_if.data_ready = 1'b1;
                @(posedge clock);
                #2 u_if.data_ready = 1'b0;
                settle();
                check("t5_valid", 32'(u_if.data_valid), 32'h1);
                check("t5_bits",  32'(u_if.data_bits),  32'h34);
            end
        join
        idle(BIT_CYC);
        settle();
        check("t5_ov",    32'(ov_cycles - o0),       32'd0);
        check("t5_count", 32'(rx_n - n0),            32'd1);
        check("t5_byte",  32'(rx_log[n0[5:0]]),      32'h12);
        check("t5_hold",  32'(u_if.data_bits),       32'h34);

        // Reset mid-frame during data bit 3 of 0x00, holding 0x34.
        @(posedge clock);
        #2 rxd = 1'b0;
        repeat (BIT_CYC * 9 / 2) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_bits",  32'(u_if.data_bits),     32'h00);
        check("t6_rst_valid", 32'(u_if.data_valid),    32'h0);
        check("t6_rst_fe",    32'(u_if.framing_error), 32'h0);
        check("t6_rst_ov",    32'(u_if.overrun),       32'h0);
        check("t6_rst_state", 32'(dut.state_q),        32'(IDLE));
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b1;
        snap();
        repeat (BIT_CYC * 4) @(posedge clock);
        #2 rxd = 1'b1;
        idle(3 * BIT_CYC);
        settle();
        check("t6_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("t6_no_fe",    32'(fe_cycles - f0),    32'd0);
        check("t6_state",    32'(dut.state_q),       32'(IDLE));
        @(posedge clock);
        #2 u_if.data_ready = 1'b1;
        snap();
        send_byte(8'h00, FAST_CYC, 1'b1, 1);
        send_byte(8'hFF, FAST_CYC, 1'b1, 1);
        idle(BIT_CYC);
        settle();
        check("t6_count", 32'(rx_n - n0),              32'd2);
        check("t6_byte0", 32'(rx_log[n0[5:0]]),        32'h00);
        check("t6_byte1", 32'(rx_log[6'(n0 + 1)]),     32'hFF);
        check("t6_fe",    32'(fe_cycles - f0),         32'd0);
        check("t6_ov",    32'(ov_cycles - o0),         32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable UART receiver: turns the asynchronous serial line from the host or a bench-side serial model into bytes on a ready/valid port. It sits behind the board RX pin, in front of the MMIO UART register block. Frame format is 8-N-1: one start bit low, 8 data bits LSB first, one stop bit high. The line idles high.

## Interface
- `CLOCK_FREQ`, 50_000_000, core clock in Hz
- `BAUD_RATE`, 115_200, line rate in bit/s
- `OVERSAMPLE`, 16, sample ticks per bit; must be even and ≥ 8

- `clock`  in  1  core clock; everything is on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset; release is synchronized externally
- `io_rxd`  in  1  serial line; asynchronous to `clock`
- `io_data_bits`  out  8  received byte
- `io_data_valid`  out  1  byte available
- `io_data_ready`  in  1  consumer accepts the byte
- `io_framing_error`  out  1  one-cycle pulse; stop bit sampled low
- `io_overrun`  out  1  one-cycle pulse; a byte was dropped because the holding register was full

## Operation
- **Input sync:** `io_rxd` passes through a 2-flop synchronizer. The synchronizer flops reset to 1.
- **Tick generator:** emits a one-cycle tick every `DIV = round(CLOCK_FREQ / (BAUD_RATE*OVERSAMPLE))` cycles.
  - The counter is `$clog2(DIV)` bits wide and wraps DIV-1 → 0.
  - It restarts at 0 on the IDLE→START transition, so phase is aligned to the start edge.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** on a synced 1→0 transition, clear the tick and sample counters and go to START.
- **START:** count ticks to `OVERSAMPLE/2`.
  - Majority-vote the three samples at ticks `OVERSAMPLE/2-1`, `OVERSAMPLE/2`, `OVERSAMPLE/2+1`.
  - Vote 1 means a false start: go back to IDLE with no output and no flag.
  - Vote 0 goes to DATA.
- **DATA:** every `OVERSAMPLE` ticks, majority-vote around mid-bit and shift the result into a shift register at the MSB, shifting right. After 8 bits, go to STOP.
- **STOP, vote 1:** deliver the byte to the holding register and go to IDLE immediately. This leaves a half-bit margin for back-to-back frames.
- **STOP, vote 0:** pulse `io_framing_error`, discard the byte and go to BREAK.
- **BREAK:** wait for the synced line to be 1, then go to IDLE.
- **Holding register:** a single entry.
  - `io_data_valid` stays high until `io_data_ready && io_data_valid`.
  - `io_data_bits` is stable while valid is high.
- **Delivery when the register is empty, or is being drained the same cycle** (ready high): load the new byte; valid is 1 in the next cycle. There is no overrun.
- **Delivery when full and not drained:** keep the old byte, drop the new one and pulse `io_overrun`.
- **Reset:** takes effect immediately at any point, including mid-frame.
  - FSM goes to IDLE; counters and shift register clear.
  - All outputs are 0: `io_data_bits`=0x00, `io_data_valid`=0, `io_framing_error`=0, `io_overrun`=0.
  - A partial frame is lost. If the line is still low after release, no start is detected until it has been high and then falls.

## Timing
- Synchronizer latency is 2 cycles.
- Start detection adds 1 more cycle, i.e. 2–3 cycles after the falling edge reaches `io_rxd`.
- `io_data_valid` rises 1 cycle after the stop-bit center vote. That is nominally 9.5 bit periods + 3 cycles after the start edge.
- `io_framing_error` and `io_overrun` each pulse for exactly 1 cycle, in the same cycle that a good byte would have loaded.
- Tolerated baud mismatch is ±3 % at `OVERSAMPLE`=16.
- Sample-tick index width is `$clog2(OVERSAMPLE)`; the bit index is 3 bits and wraps 7 → STOP.

## Structure
- Package `uart_pkg` contains:
  - the `uart_state_e` enum (IDLE, START, DATA, STOP, BREAK);
  - constant `UART_DATA_BITS` = 8;
  - function `uart_div(clock_freq, baud, oversample)`, shared with the future `uart_tx`.
- Sub-module `uart_tick_gen`, parameter DIV, with inputs `clock`, `reset_n` and `restart`, and output `tick`.
- Majority vote and the holding register are inline in `uart_rx`.

## Test plan
1. **Single byte:** `io_data_ready`=1; the bench serializes 0x55 at `BAUD_RATE`.
   - Required: `io_data_valid` high for exactly 1 cycle with `io_data_bits`=0x55.
   - No error pulses.
2. **Glitch rejection:** drive `io_rxd` low for 0.25 bit period, then high.
   - Required: no valid, no flags.
   - FSM back in IDLE; a following 0xA5 is received correctly.
3. **Framing error:** send 0xA3 with the stop bit forced low for 2 bit periods.
   - Required: one `io_framing_error` pulse and no valid.
   - After the line returns high, 0x3C is received correctly.
4. **Backpressure / overrun:** `io_data_ready`=0; send 0x12 then 0x34.
   - Required: `io_data_bits`=0x12 held, one `io_overrun` pulse at the second frame.
   - Raising ready drains 0x12 only.
5. **Simultaneous drain:** ready rises in the exact cycle the second byte 0x34 is delivered.
   - Required: no overrun; 0x34 valid on the next cycle.
6. **Reset and rate skew:**
   - Pulse `reset_n` low during data bit 3: all outputs 0 immediately, no byte delivered.
   - Then send 0x00, 0xFF back-to-back at `BAUD_RATE` × 1.025: both received in order.
